// File: rtl/lcd_controller_v2.sv
// rtl/lcd_controller_v2.sv - HD44780-class LCD bus engine with input FIFO; optional busy-flag polling via LCD_BUSY_POLL_EN
module lcd_controller_v2 #(
    parameter int BUS_WIDTH   = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int T_SETUP     = 4,
    parameter int T_PULSE     = 32,
    parameter int T_HOLD      = 4,
    parameter int T_EXEC      = 2500,
    parameter int T_EXEC_LONG = 100000
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        rs_pin,
    output logic                        rw_pin,
    output logic                        e_pin,
    output logic [7:0]                  data_pins,
    output logic                        data_oe,
    input  logic [7:0]                  data_pins_in,
    input  logic [7:0]                  data_in,
    input  logic                        data_is_cmd,
    input  logic                        data_valid,
    output logic                        data_ready,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int T_MAX_A = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int T_MAX_B = (T_HOLD > T_EXEC) ? T_HOLD : T_EXEC;
    localparam int T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int T_MAX   = (T_MAX_C > T_EXEC_LONG) ? T_MAX_C : T_EXEC_LONG;
    localparam int CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [CNT_W-1:0] LD_SETUP     = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_PULSE     = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD      = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    if (BUS_WIDTH != 8 && BUS_WIDTH != 4) begin : g_bad_bus_width
        $error("lcd_controller_v2: BUS_WIDTH must be 8 or 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("lcd_controller_v2: FIFO_DEPTH must be a power of 2, at least 2");
    end
    if (T_SETUP < 1 || T_PULSE < 1 || T_HOLD < 1 || T_EXEC < 1 || T_EXEC_LONG < 1) begin : g_bad_timing
        $error("lcd_controller_v2: all timing parameters must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_EXEC
    } state_t;

    // FIFO storage and bookkeeping; entries are {is_cmd, byte}
    logic [8:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [8:0]       head;
    logic             push;
    logic             pop;

    // Transfer engine state
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic             is_cmd_q, is_cmd_d;
    logic             nib_q, nib_d;
    logic             rs_q, rs_d;

    assign data_ready = (level_q != LVL_W'(FIFO_DEPTH));
    assign push       = data_valid && data_ready;
    assign head       = mem_q[rd_ptr_q];
    assign fifo_level = level_q;
    assign busy       = (state_q != ST_IDLE) || (level_q != '0);
    assign e_pin      = (state_q == ST_PULSE);
    assign rs_pin     = rs_q;

    // FIFO payload write; contents need no reset since the level gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {data_is_cmd, data_in};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef LCD_BUSY_POLL_EN
    localparam int TMO_W = (T_EXEC_LONG > 1) ? $clog2(T_EXEC_LONG) : 1;
    localparam logic [TMO_W-1:0] LD_TMO = TMO_W'(T_EXEC_LONG - 1);

    logic             polling_q, polling_d;
    logic             rw_q, rw_d;
    logic             oe_q, oe_d;
    logic             bf_q, bf_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             unused_pins;

    assign rw_pin      = rw_q;
    assign data_oe     = oe_q;
    assign unused_pins = ^{data_pins_in[6:0], is_cmd_q};

    // Busy-flag polling registers; the bus is released for reading only while polling
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            polling_q <= 1'b0;
            rw_q      <= 1'b0;
            oe_q      <= 1'b1;
            bf_q      <= 1'b0;
            tmo_q     <= '0;
        end else begin
            polling_q <= polling_d;
            rw_q      <= rw_d;
            oe_q      <= oe_d;
            bf_q      <= bf_d;
            tmo_q     <= tmo_d;
        end
    end
`else
    localparam logic [CNT_W-1:0] LD_EXEC      = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LD_EXEC_LONG = CNT_W'(T_EXEC_LONG - 1);

    logic exec_long;
    logic unused_pins;

    // Clear (0x01) and home (0x02/0x03) need the long execution delay
    assign exec_long   = is_cmd_q && (byte_q[7:2] == 6'b0);
    assign rw_pin      = 1'b0;
    assign data_oe     = 1'b1;
    assign unused_pins = ^data_pins_in;
`endif

    // Engine state register; reset drops E at once because e_pin decodes state_q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            byte_q   <= '0;
            is_cmd_q <= 1'b0;
            nib_q    <= 1'b0;
            rs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            byte_q   <= byte_d;
            is_cmd_q <= is_cmd_d;
            nib_q    <= nib_d;
            rs_q     <= rs_d;
        end
    end

    // Next-state logic: each timed state lasts its parameter, counting T-1 down to 0
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        byte_d   = byte_q;
        is_cmd_d = is_cmd_q;
        nib_d    = nib_q;
        rs_d     = rs_q;
        pop      = 1'b0;
`ifdef LCD_BUSY_POLL_EN
        polling_d = polling_q;
        rw_d      = rw_q;
        oe_d      = oe_q;
        bf_d      = bf_q;
        tmo_d     = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (level_q != '0) begin
                    pop      = 1'b1;
                    byte_d   = head[7:0];
                    is_cmd_d = head[8];
                    rs_d     = ~head[8];
                    nib_d    = 1'b0;
                    state_d  = ST_SETUP;
                    cnt_d    = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_PULSE;
                    cnt_d   = LD_PULSE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = LD_HOLD;
`ifdef LCD_BUSY_POLL_EN
                    if (polling_q && !nib_q) begin
                        bf_d = data_pins_in[7];
                    end
`endif
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    if (BUS_WIDTH == 4 && !nib_q) begin
                        nib_d   = 1'b1;
                        state_d = ST_SETUP;
                        cnt_d   = LD_SETUP;
                    end
`ifdef LCD_BUSY_POLL_EN
                    else if (!polling_q || bf_q) begin
                        polling_d = 1'b1;
                        rs_d      = 1'b0;
                        rw_d      = 1'b1;
                        oe_d      = 1'b0;
                        nib_d     = 1'b0;
                        state_d   = ST_SETUP;
                        cnt_d     = LD_SETUP;
                        if (!polling_q) begin
                            tmo_d = LD_TMO;
                        end
                    end else begin
                        polling_d = 1'b0;
                        rw_d      = 1'b0;
                        oe_d      = 1'b1;
                        state_d   = ST_IDLE;
                    end
`else
                    else begin
                        state_d = ST_EXEC;
                        cnt_d   = exec_long ? LD_EXEC_LONG : LD_EXEC;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef LCD_BUSY_POLL_EN
        // A display that never clears BF must not hang the engine
        if (polling_q) begin
            if (tmo_q == '0) begin
                polling_d = 1'b0;
                rw_d      = 1'b0;
                oe_d      = 1'b1;
                state_d   = ST_IDLE;
            end else begin
                tmo_d = tmo_q - TMO_W'(1);
            end
        end
`endif
    end

    // Bus data: full byte in 8-bit mode, high nibble then low nibble on [7:4] in 4-bit mode
    always_comb begin
        if (BUS_WIDTH == 4) begin
            data_pins = {(nib_q ? byte_q[3:0] : byte_q[7:4]), 4'b0000};
        end else begin
            data_pins = byte_q;
        end
    end

endmodule
